// File: rtl/pram_queue.sv
// pram_queue: write-side FIFO behind the PRAM store port.
// The producer side is a one-cycle push strobe gated by the registered full flag.
// The consumer side is a first-word-fall-through valid/ready stream.
module pram_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clear,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  push_c;
  logic                  pop_c;
  logic                  drop_c;

  // Full is judged on the registered flag only, so a same-cycle pop never rescues a push.
  always_comb begin
    push_c    = wr_en & ~full;
    drop_c    = wr_en & full;
    pop_c     = out_valid & out_ready;
    count_nxt = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy, and status flags are derived from the next-state count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count     <= count_nxt;
      full      <= (count_nxt == CW'(DEPTH));
      empty     <= (count_nxt == '0);
      out_valid <= (count_nxt != '0);
      if (drop_c)         overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  // Storage array; it is not reset, and a push in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (rst_n && push_c) mem[wr_ptr] <= wr_data;
  end

  // The head entry falls through to the output.
  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_pram_queue.sv
// Scoreboard bench for pram_queue: stimulus queues expected words, and a negedge monitor checks pops.
module tb_pram_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        ovf_clear;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];

  pram_queue #(.DATA_WIDTH(16), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ovf_clear(ovf_clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge, then settle past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 16'(i);
      exp_q.push_back(base + 16'(i));
      cyc();
    end
    wr_en = 1'b0;
  endtask

  task automatic drain_n(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
    out_ready = 1'b0;
  endtask

  // Monitor: every accepted head word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", out_data);
      end else begin
        chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; ovf_clear = 1'b0; out_ready = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // Fill then drain.
    push_n(15, 16'h0001);
    chk("fill15_full", 32'(full), 0);
    push_n(1, 16'h0010);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_head", 32'(out_data), 32'h0001);
    drain_n(16);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_sb", 32'(exp_q.size()), 0);

    // Push while full is dropped; overflow is sticky until cleared.
    push_n(16, 16'h3000);
    wr_en = 1'b1; wr_data = 16'hBEEF;
    cyc();
    wr_en = 1'b0;
    chk("ovf_count", 32'(count), 16);
    chk("ovf_set", 32'(overflow), 1);
    cyc();
    chk("ovf_sticky", 32'(overflow), 1);
    drain_n(16);
    chk("ovf_drain_empty", 32'(empty), 1);
    chk("ovf_drain_sb", 32'(exp_q.size()), 0);
    ovf_clear = 1'b1;
    cyc();
    ovf_clear = 1'b0;
    chk("ovf_clear", 32'(overflow), 0);

    // Simultaneous push and pop at full: pop proceeds, push dropped.
    push_n(16, 16'h2000);
    wr_en = 1'b1; wr_data = 16'hDEAD; out_ready = 1'b1;
    cyc();
    wr_en = 1'b0; out_ready = 1'b0;
    chk("pp_full_count", 32'(count), 15);
    chk("pp_full_ovf", 32'(overflow), 1);
    chk("pp_full_full", 32'(full), 0);
    chk("pp_full_head", 32'(out_data), 32'h2001);
    drain_n(15);
    chk("pp_drain_sb", 32'(exp_q.size()), 0);
    chk("pp_drain_empty", 32'(empty), 1);
    ovf_clear = 1'b1;
    cyc();
    ovf_clear = 1'b0;

    // Streaming with wrap-around: each word visible right after its push edge.
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 16'h0100 + 16'(i);
      exp_q.push_back(16'h0100 + 16'(i));
      cyc();
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_data", 32'(out_data), 32'h0100 + 32'(i));
      chk("stream_count_le1", 32'(count <= 5'd1), 1);
    end
    wr_en = 1'b0;
    cyc();
    out_ready = 1'b0;
    chk("stream_empty", 32'(empty), 1);
    chk("stream_sb", 32'(exp_q.size()), 0);
    chk("stream_ovf", 32'(overflow), 0);

    // Reset mid-operation discards queued data and the cycle's push.
    push_n(5, 16'h4000);
    chk("mid_count5", 32'(count), 5);
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 16'h5555;
    exp_q.delete();
    cyc();
    rst_n = 1'b1; wr_en = 1'b0;
    chk("mid_count0", 32'(count), 0);
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_empty", 32'(empty), 1);
    push_n(1, 16'h1234);
    chk("mid_head", 32'(out_data), 32'h1234);
    chk("mid_count1", 32'(count), 1);
    drain_n(1);
    chk("mid_final_empty", 32'(empty), 1);
    chk("mid_sb", 32'(exp_q.size()), 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pram_queue.md
# pram_queue

Write-side FIFO fed by the memory controller's PRAM port. Each CPU store to PRAM address 0x0000 arrives as a one-cycle write strobe and is pushed into the queue. The registered `full` flag goes back to the memory controller, which returns it to the CPU as bit 0 on PRAM reads so software can poll before storing. The consumer side is a valid/ready stream with first-word-fall-through.

## Interface
- `DATA_WIDTH`, 16: width of each queue entry.
- `DEPTH_LOG2`, 4: log2 of the entry count (16 entries by default).

Ports (name, direction, width, meaning):
- `clk`, in, 1: single system clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `wr_data`, in, DATA_WIDTH: push data (PRAM_Out).
- `wr_en`, in, 1: push strobe (PRAM_Wr_En); each cycle high is one push attempt.
- `full`, out, 1: registered; high when count == 2^DEPTH_LOG2.
- `empty`, out, 1: registered; high when count == 0.
- `count`, out, DEPTH_LOG2+1: registered occupancy, 0..2^DEPTH_LOG2.
- `overflow`, out, 1: sticky; set when a push is dropped.
- `ovf_clear`, in, 1: clears `overflow`.
- `out_data`, out, DATA_WIDTH: head entry (mem[rd_ptr]); valid only while `out_valid` is high.
- `out_valid`, out, 1: equals !empty.
- `out_ready`, in, 1: consumer accepts the head entry this cycle.

## Operation
- Storage is a register array of 2^DEPTH_LOG2 entries.
- Pointers:
  - `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `count` is tracked separately and is one bit wider.
- push = wr_en & !full, using the registered `full`.
  - On push: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr + 1.
- pop = out_valid & out_ready.
  - On pop: rd_ptr <= rd_ptr + 1.
- count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- `full` and `empty` are recomputed from the next-state count and registered.
- Drop rule: if wr_en is high while full, the data is discarded, nothing changes, and `overflow` <= 1.
  - This applies even when a pop happens in the same cycle. Full is decided on the registered flag only, matching what the CPU polled.
- Overflow clearing:
  - `overflow` clears on ovf_clear.
  - If a drop and ovf_clear occur in the same cycle, the set wins and `overflow` stays 1.
- Push and pop both allowed when 0 < count < depth: both pointers advance and count holds.
- Push into an empty queue:
  - No pop is possible that cycle, since out_valid = 0.
  - The entry is visible on out_data with out_valid = 1 in the next cycle.
- Pop of the last entry: out_valid falls the cycle after the pop edge.
- `out_data` is unspecified while out_valid = 0. The verifier must not check it then.

## Timing
- Reset: on a rising edge with rst_n = 0:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, out_valid = 0, overflow = 0.
  - Array contents are don't-care.
  - Reset mid-operation discards all queued data, and the cycle's push/pop is ignored.
- Latency:
  - A push at edge N gives out_valid = 1 and out_data = pushed word after edge N.
  - A push at edge N is reflected in full/count after edge N.
- Pop throughput: one entry per cycle while out_ready is held high.
- The CPU sees the updated `full` on a PRAM read one cycle after its store. Software polling has a one-store window; with the drop rule that window is safe.
- No combinational path from wr_en to full, or from out_ready to out_valid.

## Test plan
- Reset then idle: hold rst_n = 0 for 2 cycles, release -> empty = 1, full = 0, count = 0, out_valid = 0, overflow = 0.
- Fill and drain:
  - Push 0x0001..0x0010 on 16 consecutive cycles with out_ready = 0 -> full = 1 and count = 16 after the 16th edge.
  - Then out_ready = 1 for 16 cycles -> 0x0001..0x0010 appear in order, then empty = 1.
- Overflow:
  - With 16 entries and out_ready = 0, push 0xBEEF -> count stays 16 and overflow = 1.
  - Drain all 16 -> 0xBEEF is never seen.
  - Pulse ovf_clear -> overflow = 0.
- Simultaneous push/pop at full: count = 16, wr_en = 1 and out_ready = 1 in the same cycle -> the push is dropped, count = 15, overflow = 1.
- Wrap-around streaming:
  - Push 40 words 0x0100+i with out_ready = 1 every cycle -> each word appears the cycle after its push and count never exceeds 1.
  - Pointers wrap twice with no data loss.
- Reset mid-operation: with 5 entries queued, assert rst_n = 0 for one edge -> count = 0, out_valid = 0. The next push of 0x1234 is the head.
